// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer on clock_in; define PLL_SEQ_AUTO_RETRY_EN to retry instead of faulting.
// Latency: lock seen 2 cycles after locked; release STABLE_CYCLES cycles after STABLE entry.
// Backpressure: none; restart is a single-cycle request honoured on the next edge.
module pll_reset_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 16000,
  parameter int unsigned STABLE_CYCLES = 256
) (
  input  logic       clock_in,
  input  logic       resetb,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] fault_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [15:0] RST_LOAD    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LOAD   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LOAD = 16'(STABLE_CYCLES - 1);

  state_t      cur_state, nxt_state;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  fc_nxt;
  logic        sync1, lock_s;
  logic        evt;

  function automatic logic [15:0] load_for(input state_t s);
    case (s)
      S_RESET_PLL: load_for = RST_LOAD;
      S_WAIT_LOCK: load_for = LOCK_LOAD;
      S_STABLE:    load_for = STABLE_LOAD;
      default:     load_for = 16'd0;
    endcase
  endfunction

  // locked is asynchronous to clock_in
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= locked;
      lock_s <= sync1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    evt       = 1'b0;
    case (cur_state)
      S_RESET_PLL: if (cnt == 16'd0) nxt_state = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s)              nxt_state = S_STABLE;
        else if (cnt == 16'd0)   evt = 1'b1;
      end
      S_STABLE: begin
        if (!lock_s)             evt = 1'b1;
        else if (cnt == 16'd0)   nxt_state = S_RUN;
      end
      S_RUN:   if (!lock_s) evt = 1'b1;
      S_FAULT: nxt_state = S_FAULT;
      default: nxt_state = S_RESET_PLL;
    endcase
    if (evt) begin
`ifdef PLL_SEQ_AUTO_RETRY_EN
      nxt_state = S_RESET_PLL;
`else
      nxt_state = S_FAULT;
`endif
    end
    if (restart) nxt_state = S_RESET_PLL;

    // every state entry (and any restart) reloads the shared counter
    if (restart || nxt_state != cur_state) cnt_nxt = load_for(nxt_state);
    else if (cnt != 16'd0)                 cnt_nxt = cnt - 16'd1;
    else                                   cnt_nxt = cnt;

    fc_nxt = fault_count;
    if (evt && !restart && fault_count != 8'hFF) fc_nxt = fault_count + 8'd1;
  end

  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      cur_state   <= S_RESET_PLL;
      cnt         <= RST_LOAD;
      fault_count <= 8'd0;
      pll_resetb  <= 1'b0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      cnt         <= cnt_nxt;
      fault_count <= fc_nxt;
      pll_resetb  <= (nxt_state != S_RESET_PLL);
      sys_reset_n <= (nxt_state == S_RUN);
      ready       <= (nxt_state == S_RUN);
      fault       <= (nxt_state == S_FAULT);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed scenarios plus randomized lock/restart traffic.
// Latency: reference model tracks elapsed time per phase and the 2-edge lock delay.
// Backpressure: none; inputs driven on the falling edge, outputs compared on the falling edge.
module tb_pll_reset_seq;

  localparam int RST = 16;
  localparam int TO  = 100;
  localparam int ST  = 256;
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FLT = 4;
`ifdef PLL_SEQ_AUTO_RETRY_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetb, locked, restart;
  logic       pll_resetb, sys_reset_n, ready, fault;
  logic [7:0] fault_count;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase, cycles spent in phase, fault count, locked history
  int   m_ph, m_t, m_fc;
  logic m_d1, m_d2;

  pll_reset_seq #(.RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST)) dut (
    .clock_in(clk), .resetb(resetb), .locked(locked), .restart(restart),
    .pll_resetb(pll_resetb), .sys_reset_n(sys_reset_n), .ready(ready),
    .fault(fault), .fault_count(fault_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic [14:0] v;
    v = {3'(m_ph), (m_ph != P_RST), (m_ph == P_RUN), (m_ph == P_RUN), (m_ph == P_FLT), 8'(m_fc)};
    return {17'd0, v};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {17'd0, state, pll_resetb, sys_reset_n, ready, fault, fault_count};
  endfunction

  task automatic model_reset();
    m_ph = P_RST; m_t = 0; m_fc = 0; m_d1 = 1'b0; m_d2 = 1'b0;
  endtask

  // one clock: drive inputs, advance model by the spec rules, compare after the edge
  task automatic step(input logic lk, input logic rs);
    bit ev;
    locked  = lk;
    restart = rs;
    ev = 1'b0;
    if (rs) begin
      m_ph = P_RST; m_t = 0;
    end else begin
      case (m_ph)
        P_RST:  if (m_t == RST - 1) begin m_ph = P_WAIT; m_t = 0; end else m_t++;
        P_WAIT: if (m_d2) begin m_ph = P_STAB; m_t = 0; end
                else if (m_t == TO - 1) ev = 1'b1;
                else m_t++;
        P_STAB: if (!m_d2) ev = 1'b1;
                else if (m_t == ST - 1) begin m_ph = P_RUN; m_t = 0; end
                else m_t++;
        P_RUN:  if (!m_d2) ev = 1'b1;
        default: ;
      endcase
    end
    if (ev) begin
      if (m_fc < 255) m_fc++;
      m_ph = AUTO ? P_RST : P_FLT;
      m_t  = 0;
    end
    m_d2 = m_d1;
    m_d1 = lk;
    @(posedge clk);
    @(negedge clk);
    check("outs", dut_vec(), exp_vec());
  endtask

  initial begin
    int n;
    int fcb;
    resetb = 1'b0; locked = 1'b0; restart = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", dut_vec(), exp_vec());
    resetb = 1'b1;

    // bring-up with default-style lock timing
    n = 0;
    while (pll_resetb == 1'b0 && n < 100) begin step(1'b0, 1'b0); n++; end
    check("rst_len", n, RST);
    for (int k = 0; k < 39; k++) step(1'b0, 1'b0);
    n = 1;
    step(1'b1, 1'b0);
    while (state != 3'd2 && n < 10) begin step(1'b1, 1'b0); n++; end
    check("lock_lat", n, 3);
    n = 0;
    while (ready == 1'b0 && n < 400) begin step(1'b1, 1'b0); n++; end
    check("stable_len", n, ST);
    check("sysrst_run", sys_reset_n, 1);

    // one-cycle lock drop in RUN
    n = 1;
    step(1'b0, 1'b0);
    while (sys_reset_n == 1'b1 && n < 10) begin step(1'b1, 1'b0); n++; end
    check("drop_lat", n, 3);
    check("drop_fc", fault_count, 1);
    check("drop_state", state, AUTO ? P_RST : P_FLT);
    check("drop_fault", fault, AUTO ? 0 : 1);
    step(1'b1, 1'b1);
    check("restart_state", state, P_RST);

    // lock drop at cycle 100 of STABLE, then a clean STABLE interval
    n = 0;
    while (state != 3'd2 && n < 300) begin step(1'b1, 1'b0); n++; end
    check("reach_stable", state, P_STAB);
    for (int k = 0; k < 99; k++) step(1'b1, 1'b0);
    fcb = m_fc;
    step(1'b0, 1'b0);
    n = 0;
    while (state == 3'd2 && n < 10) begin step(1'b1, 1'b0); n++; end
    check("stable_drop_fc", fault_count, fcb + 1);
    check("stable_drop_noready", ready, 0);
    if (state == 3'd4) step(1'b1, 1'b1);
    n = 0;
    while (state != 3'd2 && n < 400) begin step(1'b1, 1'b0); n++; end
    n = 0;
    while (ready == 1'b0 && n < 400) begin step(1'b1, 1'b0); n++; end
    check("stable_len2", n, ST);

    // randomized regimes of lock behaviour with sporadic restarts
    for (int i = 0; i < 15000 && n_fail < 30; ) begin
      int len, mode;
      len  = $urandom_range(50, 400);
      mode = $urandom_range(0, 3);
      for (int j = 0; j < len; j++) begin
        logic lk, rs;
        case (mode)
          0:       lk = 1'b1;
          1:       lk = 1'b0;
          2:       lk = ($urandom_range(0, 19) != 0);
          default: lk = 1'($urandom_range(0, 1));
        endcase
        rs = ($urandom_range(0, 299) == 0) || (m_ph == P_FLT && $urandom_range(0, 29) == 0);
        step(lk, rs);
        i++;
      end
    end

    // restart coinciding with a WAIT_LOCK timeout
    n = 0;
    while (!(m_ph == P_WAIT && m_t == TO - 1 && !m_d2) && n < 2000 && n_fail < 30) begin
      step(1'b0, m_ph == P_FLT);
      n++;
    end
    check("reach_timeout_edge", state, P_WAIT);
    fcb = m_fc;
    step(1'b0, 1'b1);
    check("restart_vs_timeout_state", state, P_RST);
    check("restart_vs_timeout_fc", fault_count, fcb);

    // saturation of fault_count under permanent loss of lock
    n = 0;
    while (m_fc < 255 && n < 45000 && n_fail < 30) begin
      step(1'b0, m_ph == P_FLT);
      n++;
    end
    for (int k = 0; k < 400 && n_fail < 30; k++) step(1'b0, m_ph == P_FLT);
    check("fc_sat", fault_count, 255);

    // asynchronous reset in the middle of RUN
    step(1'b1, 1'b1);
    n = 0;
    while (ready == 1'b0 && n < 800) begin step(1'b1, 1'b0); n++; end
    check("reach_run", state, P_RUN);
    #2 resetb = 1'b0;
    #1;
    check("async_pll_resetb", pll_resetb, 0);
    check("async_sys_reset_n", sys_reset_n, 0);
    model_reset();
    check("async_outs", dut_vec(), exp_vec());
    @(negedge clk);
    resetb = 1'b1;
    check("async_hold_outs", dut_vec(), exp_vec());
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter RST_CYCLES, default 16: clock_in cycles pll_resetb is held low per PLL restart; legal 1..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 16000: cycles allowed in WAIT_LOCK before the attempt is declared failed (1 ms at 16 MHz); legal 1..65535.
REQ-003 Parameter STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required before release; legal 1..65535.
REQ-004 clock_in  input  1  reference clock (16 MHz); the whole block runs on it, never on the PLL output.
REQ-005 resetb  input  1  asynchronous, active-low reset.
REQ-006 locked  input  1  PLL lock indicator; asynchronous to clock_in.
REQ-007 restart  input  1  single-cycle request to restart the PLL.
REQ-008 pll_resetb  output  1  drives the PLL RESETB pin; low holds the PLL in reset.
REQ-009 sys_reset_n  output  1  active-low reset for logic clocked by the PLL output; the consuming domain resynchronizes it.
REQ-010 ready  output  1  high only in RUN.
REQ-011 fault  output  1  high only in FAULT.
REQ-012 fault_count  output  8  saturating count of lock timeouts plus lock losses.
REQ-013 state  output  3  current state encoding, for debug: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-014 Synchronize locked through two clock_in flops to give lock_s; every decision uses lock_s only.
REQ-015 Use a single 16-bit down-counter, shared by all states and reloaded on every state entry.
REQ-016 RESET_PLL: pll_resetb=0; load RST_CYCLES-1; on reaching 0 go to WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_resetb=1; load LOCK_TIMEOUT-1; lock_s=1 -> STABLE; counter at 0 with lock_s=0 -> timeout event.
REQ-018 STABLE: load STABLE_CYCLES-1; lock_s=0 -> lock-loss event; counter at 0 with lock_s=1 -> RUN.
REQ-019 The first cycle of RUN is exactly STABLE_CYCLES cycles after entry to STABLE when lock_s stays high.
REQ-020 RUN: sys_reset_n=1 and ready=1; lock_s=0 -> lock-loss event.
REQ-021 sys_reset_n is registered, is 0 in every state except RUN, and falls in the first cycle after leaving RUN.
REQ-022 A timeout or lock-loss event increments fault_count by 1, saturating at 255.
REQ-023 A lock drop during STABLE counts as a lock-loss event.
REQ-024 restart=1 in any state -> RESET_PLL next cycle, with the counter reloaded.
REQ-025 restart does not increment fault_count.
REQ-026 restart has priority over a timeout or lock-loss event in the same cycle, and that event is not counted.
REQ-027 FAULT: pll_resetb=1, sys_reset_n=0, fault=1; leave only on restart.
REQ-028 fault_count clears only on resetb.

Reset
REQ-029 While resetb=0: state=RESET_PLL, counter=RST_CYCLES-1, pll_resetb=0, sys_reset_n=0, ready=0, fault=0, fault_count=0, both sync flops=0.
REQ-030 resetb asserts asynchronously; release takes effect on the next clock_in edge.
REQ-031 After reset release, a full RESET_PLL interval runs before WAIT_LOCK.
REQ-032 resetb asserted mid-operation, including in RUN, drops sys_reset_n and pll_resetb immediately.

Configuration
REQ-033 The feature is selected by macro PLL_SEQ_AUTO_RETRY_EN.
REQ-034 With PLL_SEQ_AUTO_RETRY_EN defined: a timeout or lock-loss event -> RESET_PLL; FAULT is unreachable; fault stays 0.
REQ-035 Without PLL_SEQ_AUTO_RETRY_EN: a timeout or lock-loss event -> FAULT, where the block waits for restart.
REQ-036 fault_count counts identically in both builds.

Verification
REQ-037 Defaults; locked rises 40 cycles after pll_resetb rises and stays high -> pll_resetb low for 16 cycles after reset release; lock_s seen 2 cycles after locked; ready and sys_reset_n rise 256 cycles after STABLE entry.
REQ-038 RUN; locked drops for 1 cycle -> sys_reset_n=0 within 3 cycles of the drop; fault_count=1; with macro, RESET_PLL follows; without macro, FAULT, fault=1.
REQ-039 locked held low, macro defined -> timeout after 16000 WAIT_LOCK cycles, loop repeats, fault_count saturates at 255 after 255 timeouts.
REQ-040 STABLE; locked drops at cycle 100 of 256 -> no release; fault_count increments; the counter is reloaded on the next STABLE entry.
REQ-041 restart in the same cycle as a WAIT_LOCK timeout -> RESET_PLL; fault_count unchanged; without macro, restart from FAULT also -> RESET_PLL.
REQ-042 resetb pulsed low asynchronously mid-RUN -> sys_reset_n and pll_resetb fall before the next clock_in edge; all outputs take their reset values; fault_count=0.
